// File: rtl/vga_pkg.sv
// Shared types and sizing helpers for the pixel-domain stream controller.
// Also used by the timing generator through vga_pix_counter.
package vga_pkg;

  localparam int HDISP_DEF = 800;
  localparam int VDISP_DEF = 480;

  typedef enum logic [1:0] {
    PREFILL = 2'd0,
    ARM     = 2'd1,
    STREAM  = 2'd2,
    RESYNC  = 2'd3
  } state_e;

  // Width of a counter holding 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_stream_ctrl_if.sv
// FIFO-read and page-flip signals between the controller and its peers.
// master = controller side, slave = FIFO / page-flip requester side.
interface vga_stream_ctrl_if #(
  parameter int ADDR_W = 32
);

  logic              fifo_almost_full_i;
  logic              fifo_empty_i;
  logic              fifo_read_o;
  logic              swap_req_i;
  logic [ADDR_W-1:0] back_base_i;
  logic [ADDR_W-1:0] frame_base_o;
  logic              swap_ack_o;

  modport master (
    input  fifo_almost_full_i,
    input  fifo_empty_i,
    input  swap_req_i,
    input  back_base_i,
    output fifo_read_o,
    output frame_base_o,
    output swap_ack_o
  );

  modport slave (
    output fifo_almost_full_i,
    output fifo_empty_i,
    output swap_req_i,
    output back_base_i,
    input  fifo_read_o,
    input  frame_base_o,
    input  swap_ack_o
  );

endinterface

// File: rtl/vga_pix_counter.sv
// Active-pixel x/y counter with enable, clear and end-of-frame flag.
// Clear has priority over enable.
module vga_pix_counter
  import vga_pkg::*;
#(
  parameter int HDISP = HDISP_DEF,
  parameter int VDISP = VDISP_DEF,
  localparam int XW = cnt_w(HDISP),
  localparam int YW = cnt_w(VDISP)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          clr_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          eof_o
);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          x_last;
  logic          y_last;

  assign x_last = (x_q == XW'(HDISP - 1));
  assign y_last = (y_q == YW'(VDISP - 1));
  assign eof_o  = en_i && x_last && y_last;
  assign x_o    = x_q;
  assign y_o    = y_q;

  // Next position: wrap x at line end, wrap y at frame end.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else if (en_i) begin
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/vga_stream_ctrl.sv
// Frame-buffer read sequencer: prefill, VS-qualified start, underflow resync
// and end-of-frame page flip. Optional counters under UNDERFLOW_STATS_EN.
module vga_stream_ctrl
  import vga_pkg::*;
#(
  parameter int HDISP         = HDISP_DEF,
  parameter int VDISP         = VDISP_DEF,
  parameter int ADDR_W        = 32,
  parameter int RESYNC_CYCLES = 16,
  localparam int XW = cnt_w(HDISP),
  localparam int YW = cnt_w(VDISP)
) (
  input  logic                pixel_clk,
  input  logic                pixel_rst,
  input  logic                blank_i,
  input  logic                vs_i,
  vga_stream_ctrl_if.master   bus,
  output logic                resync_o,
  output logic                streaming_o,
  output logic [XW-1:0]       x_o,
  output logic [YW-1:0]       y_o
`ifdef UNDERFLOW_STATS_EN
  ,
  output logic [15:0]         underflow_cnt_o,
  output logic [15:0]         frame_cnt_o
`endif
);

  localparam int TW = cnt_w(RESYNC_CYCLES);

  state_e            state_q, state_d;
  logic              vs_seen_q, vs_seen_d;
  logic              blank_q;
  logic [TW-1:0]     rs_cnt_q, rs_cnt_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_base_q, pend_base_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              streaming_q;

  logic go;
  logic rd;
  logic underflow;
  logic eof;
  logic apply;
  logic rs_done;

  // First blank rise after a VS low starts streaming on that same pixel.
  assign go = (state_q == ARM) && vs_seen_q
           && blank_i && !blank_q;
  assign rd = blank_i && ((state_q == STREAM) || go);
  assign underflow = (state_q == STREAM) && rd
                  && bus.fifo_empty_i;
  assign rs_done = (rs_cnt_q == TW'(RESYNC_CYCLES - 1));

  vga_pix_counter #(
    .HDISP (HDISP),
    .VDISP (VDISP)
  ) u_pix (
    .clk_i (pixel_clk),
    .rst_i (pixel_rst),
    .en_i  (rd),
    .clr_i (underflow),
    .x_o   (x_o),
    .y_o   (y_o),
    .eof_o (eof)
  );

  // State register.
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) state_q <= PREFILL;
    else           state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PREFILL: if (bus.fifo_almost_full_i) state_d = ARM;
      ARM:     if (go)                     state_d = STREAM;
      STREAM:  if (underflow)              state_d = RESYNC;
      RESYNC:  if (rs_done)                state_d = PREFILL;
    endcase
  end

  // Output decode.
  always_comb begin
    bus.fifo_read_o  = rd;
    bus.swap_ack_o   = apply;
    bus.frame_base_o = base_q;
    resync_o         = (state_q == RESYNC);
    streaming_o      = streaming_q;
  end

  // VS flag lives only in ARM, so it is clear on every ARM entry.
  always_comb begin
    vs_seen_d = vs_seen_q;
    if (state_q != ARM) vs_seen_d = 1'b0;
    else if (!vs_i)     vs_seen_d = 1'b1;
  end

  // Resync hold timer counts cycles spent in RESYNC.
  always_comb begin
    rs_cnt_d = '0;
    if (state_q == RESYNC) rs_cnt_d = rs_cnt_q + 1'b1;
  end

  // Flip at frame end, or right away when the reader restarts anyway.
  // A request in the apply cycle is kept for the next opportunity.
  always_comb begin
    apply = pend_q && (eof || underflow
         || (state_q == RESYNC) || (state_q == PREFILL));
    pend_d      = pend_q;
    pend_base_d = pend_base_q;
    base_d      = base_q;
    if (apply) begin
      base_d = pend_base_q;
      pend_d = 1'b0;
    end
    if (bus.swap_req_i) begin
      pend_d      = 1'b1;
      pend_base_d = bus.back_base_i;
    end
  end

  // Control and page-flip registers.
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      vs_seen_q   <= 1'b0;
      blank_q     <= 1'b0;
      rs_cnt_q    <= '0;
      pend_q      <= 1'b0;
      pend_base_q <= '0;
      base_q      <= '0;
      streaming_q <= 1'b0;
    end else begin
      vs_seen_q   <= vs_seen_d;
      blank_q     <= blank_i;
      rs_cnt_q    <= rs_cnt_d;
      pend_q      <= pend_d;
      pend_base_q <= pend_base_d;
      base_q      <= base_d;
      streaming_q <= (state_d == STREAM);
    end
  end

`ifdef UNDERFLOW_STATS_EN
  logic [15:0] ucnt_q;
  logic [15:0] fcnt_q;

  // Saturating underflow count and wrapping frame count.
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      ucnt_q <= '0;
      fcnt_q <= '0;
    end else begin
      if (underflow && (ucnt_q != 16'hFFFF))
        ucnt_q <= ucnt_q + 16'd1;
      if (eof)
        fcnt_q <= fcnt_q + 16'd1;
    end
  end

  assign underflow_cnt_o = ucnt_q;
  assign frame_cnt_o     = fcnt_q;
`endif

endmodule
